// File: rtl/display_timings_480p.sv
// 640x480@60 raster timing generator: position, syncs, de, strobes.
// Optional colour bars under DISPLAY_TIMINGS_480P_PATTERN_EN.
module display_timings_480p #(
  parameter int   CORDW  = 16,
  parameter int   H_RES  = 640,
  parameter int   H_FP   = 16,
  parameter int   H_SYNC = 96,
  parameter int   H_BP   = 48,
  parameter int   V_RES  = 480,
  parameter int   V_FP   = 10,
  parameter int   V_SYNC = 2,
  parameter int   V_BP   = 33,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [15:0]      frame_cnt,
  output logic [3:0]       r,
  output logic [3:0]       g,
  output logic [3:0]       b
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HS_STA  = H_RES + H_FP;
  localparam int HS_END  = HS_STA + H_SYNC - 1;
  localparam int VS_STA  = V_RES + V_FP;
  localparam int VS_END  = VS_STA + V_SYNC - 1;

  logic [CORDW-1:0] hc_q, hc_d;
  logic [CORDW-1:0] vc_q, vc_d;
  logic [CORDW-1:0] sx_q, sy_q;
  logic             hs_q, vs_q, de_q, line_q, frame_q;
  logic [15:0]      fcnt_q;
  logic             hs_d, vs_d, de_d, line_d, frame_d;

  // Raster counters: hc wraps every line, vc advances on hc wrap.
  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == CORDW'(H_TOTAL - 1)) begin
      hc_d = '0;
      if (vc_q == CORDW'(V_TOTAL - 1)) vc_d = '0;
      else                             vc_d = vc_q + 1'b1;
    end
  end

  // Decode the current position into timing signals.
  always_comb begin
    de_d    = (hc_q < CORDW'(H_RES)) && (vc_q < CORDW'(V_RES));
    hs_d    = ~H_POL;
    vs_d    = ~V_POL;
    line_d  = (hc_q == '0);
    frame_d = (hc_q == '0) && (vc_q == '0);
    if (hc_q >= CORDW'(HS_STA) && hc_q <= CORDW'(HS_END)) hs_d = H_POL;
    if (vc_q >= CORDW'(VS_STA) && vc_q <= CORDW'(VS_END)) vs_d = V_POL;
  end

  // Counter state.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Registered outputs, all describing the same pixel.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      sx_q    <= hc_q;
      sy_q    <= vc_q;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      if (frame_d) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign sx        = sx_q;
  assign sy        = sy_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign de        = de_q;
  assign line      = line_q;
  assign frame     = frame_q;
  assign frame_cnt = fcnt_q;

`ifdef DISPLAY_TIMINGS_480P_PATTERN_EN
  localparam int BAR_W = H_RES / 8;

  logic [2:0] bar;
  logic [3:0] r_q, g_q, b_q;

  // Which of the eight vertical bars the current pixel falls in.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++)
      if (hc_q >= CORDW'(i * BAR_W)) bar = 3'(i);
  end

  // Bar colour, blanked outside the active area.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= de_d ? {4{~bar[1]}} : 4'h0;
      g_q <= de_d ? {4{~bar[2]}} : 4'h0;
      b_q <= de_d ? {4{~bar[0]}} : 4'h0;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
`else
  assign r = 4'h0;
  assign g = 4'h0;
  assign b = 4'h0;
`endif

endmodule

// File: tb/tb_display_timings_480p.sv
// Bench for display_timings_480p: default raster plus a
// small-geometry instance for whole-frame checks.
module tb_display_timings_480p;

  logic        clk = 1'b0;
  logic        rst_n, rst_b_n;
  logic [15:0] sx_a, sy_a, fc_a;
  logic        hs_a, vs_a, de_a, ln_a, fr_a;
  logic [3:0]  r_a, g_a, b_a;
  logic [15:0] sx_b, sy_b, fc_b;
  logic        hs_b, vs_b, de_b, ln_b, fr_b;
  logic [3:0]  r_b, g_b, b_b;

  always #5 clk = ~clk;

  display_timings_480p dut_a (
    .clk_pix(clk), .rst_n(rst_n),
    .sx(sx_a), .sy(sy_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .line(ln_a), .frame(fr_a), .frame_cnt(fc_a),
    .r(r_a), .g(g_a), .b(b_a)
  );

  // H_TOTAL=25, V_TOTAL=11, frame = 275 cycles
  display_timings_480p #(
    .CORDW(16), .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .clk_pix(clk), .rst_n(rst_b_n),
    .sx(sx_b), .sy(sy_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .line(ln_b), .frame(fr_b), .frame_cnt(fc_b),
    .r(r_b), .g(g_b), .b(b_b)
  );

  typedef struct {
    int k;
    int sx;
    int sy;
    int de;
    int hs;
    int vs;
    int ln;
    int fr;
    int fc;
  } vec_t;

  vec_t vt[11];

  int nchk = 0;
  int npass = 0;
  int k = 0;
  int kb = 0;
  bit b_run = 1'b0;
  int de_cnt = 0, hs_cnt = 0, rgb_bad = 0;
  int nfr = 0, fr1 = 0, fr2 = 0, fc2 = 0;
  int deb = 0, vsb = 0, lnb = 0, vsbad = 0;
  int sxl = 0, syl = 0, syw = -1, frw = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      npass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (k >= 1 && k <= 800) begin
      if (de_a) de_cnt++;
      if (!hs_a) hs_cnt++;
    end
    if (|{r_a, g_a, b_a}) rgb_bad++;
    if (b_run) begin
      kb++;
      if (fr_b) begin
        if (nfr == 0) fr1 = kb;
        else if (nfr == 1) begin
          fr2 = kb;
          fc2 = int'(fc_b);
        end
        nfr++;
      end
      if (kb <= 275) begin
        if (de_b) deb++;
        if (!vs_b) vsb++;
        if (ln_b) lnb++;
      end
      if (!vs_b && !(sy_b == 7 || sy_b == 8)) vsbad++;
      if (kb == 275) begin
        sxl = int'(sx_b);
        syl = int'(sy_b);
      end
      if (kb == 276) begin
        syw = int'(sy_b);
        frw = int'(fr_b);
      end
    end
  endtask

  initial begin
    //           k     sx  sy de hs vs ln fr fc
    vt[0]  = '{1,     0,  0, 1, 1, 1, 1, 1, 1};
    vt[1]  = '{2,     1,  0, 1, 1, 1, 0, 0, 1};
    vt[2]  = '{640, 639,  0, 1, 1, 1, 0, 0, 1};
    vt[3]  = '{641, 640,  0, 0, 1, 1, 0, 0, 1};
    vt[4]  = '{656, 655,  0, 0, 1, 1, 0, 0, 1};
    vt[5]  = '{657, 656,  0, 0, 0, 1, 0, 0, 1};
    vt[6]  = '{752, 751,  0, 0, 0, 1, 0, 0, 1};
    vt[7]  = '{753, 752,  0, 0, 1, 1, 0, 0, 1};
    vt[8]  = '{800, 799,  0, 0, 1, 1, 0, 0, 1};
    vt[9]  = '{801,   0,  1, 1, 1, 1, 1, 0, 1};
    vt[10] = '{1441, 640, 1, 0, 1, 1, 0, 0, 1};

    rst_n   = 1'b0;
    rst_b_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst.sx", int'(sx_a), 0);
    chk("rst.sy", int'(sy_a), 0);
    chk("rst.de", int'(de_a), 0);
    chk("rst.line", int'(ln_a), 0);
    chk("rst.frame", int'(fr_a), 0);
    chk("rst.fcnt", int'(fc_a), 0);
    chk("rst.hsync", int'(hs_a), 1);
    chk("rst.vsync", int'(vs_a), 1);
    chk("rst.rgb", int'({r_a, g_a, b_a}), 0);

    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 11; i++) begin
      while (k < vt[i].k) step();
      chk($sformatf("v%0d.sx", i), int'(sx_a), vt[i].sx);
      chk($sformatf("v%0d.sy", i), int'(sy_a), vt[i].sy);
      chk($sformatf("v%0d.de", i), int'(de_a), vt[i].de);
      chk($sformatf("v%0d.hsync", i), int'(hs_a), vt[i].hs);
      chk($sformatf("v%0d.vsync", i), int'(vs_a), vt[i].vs);
      chk($sformatf("v%0d.line", i), int'(ln_a), vt[i].ln);
      chk($sformatf("v%0d.frame", i), int'(fr_a), vt[i].fr);
      chk($sformatf("v%0d.fcnt", i), int'(fc_a), vt[i].fc);
    end
    chk("line.de_cycles", de_cnt, 640);
    chk("line.hsync_cycles", hs_cnt, 96);

    // mid-frame asynchronous reset at sx=300, sy=2
    while (k < 1901) step();
    chk("mid.pre_sx", int'(sx_a), 300);
    chk("mid.pre_sy", int'(sy_a), 2);
    rst_n = 1'b0;
    #2;
    chk("mid.async_sx", int'(sx_a), 0);
    chk("mid.async_sy", int'(sy_a), 0);
    chk("mid.async_de", int'(de_a), 0);
    chk("mid.async_fcnt", int'(fc_a), 0);
    chk("mid.async_hsync", int'(hs_a), 1);
    @(posedge clk);
    #1;
    chk("mid.held_sx", int'(sx_a), 0);
    chk("mid.held_frame", int'(fr_a), 0);
    rst_n = 1'b1;
    k = 0;
    step();
    chk("restart.sx", int'(sx_a), 0);
    chk("restart.sy", int'(sy_a), 0);
    chk("restart.de", int'(de_a), 1);
    chk("restart.frame", int'(fr_a), 1);
    chk("restart.fcnt", int'(fc_a), 1);
    step();
    chk("restart2.sx", int'(sx_a), 1);
    chk("restart2.frame", int'(fr_a), 0);

    // row sy=10: edge k shows pixel k-1
    while (k < 8080) step();
    chk("pat.sx79", int'(sx_a), 79);
`ifdef DISPLAY_TIMINGS_480P_PATTERN_EN
    chk("pat.rgb79", int'({r_a, g_a, b_a}), 'hFFF);
    step();
    chk("pat.rgb80", int'({r_a, g_a, b_a}), 'hFF0);
    while (k < 8640) step();
    chk("pat.rgb639", int'({r_a, g_a, b_a}), 'h000);
    step();
    chk("pat.rgb640", int'({r_a, g_a, b_a}), 'h000);
    chk("pat.de640", int'(de_a), 0);
`else
    while (k < 8641) step();
    chk("nopat.rgb_nonzero_cycles", rgb_bad, 0);
`endif
    chk("pat.sx640", int'(sx_a), 640);
    chk("pat.sy", int'(sy_a), 10);

    // small-geometry frame checks
    rst_b_n = 1'b1;
    b_run = 1'b1;
    kb = 0;
    repeat (560) step();
    chk("b.first_frame_edge", fr1, 1);
    chk("b.frame_period", fr2 - fr1, 275);
    chk("b.fcnt_second", fc2, 2);
    chk("b.frame_strobes", nfr, 3);
    chk("b.de_cycles", deb, 96);
    chk("b.vsync_cycles", vsb, 50);
    chk("b.vsync_outside", vsbad, 0);
    chk("b.line_strobes", lnb, 11);
    chk("b.last_sx", sxl, 24);
    chk("b.last_sy", syl, 10);
    chk("b.wrap_sy", syw, 0);
    chk("b.wrap_frame", frw, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
